dmem_hs: RTL and testbench

Handshaked, parametrised byte-addressable data memory for the CPU load/store stage. It keeps the existing big-endian byte ordering and B/H/W/D access sizes, and adds:
- valid/ready request and response channels with configurable latency
- sign/zero extension of loads
- range checking and an error flag
- self-clearing after reset

It sits between the MEM stage and backing storage. One request is outstanding at a time.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_lane_fmt.sv | 45 ++++
 rtl/dmem_hs.sv | 150 +++++++++++++++
 tb/tb_dmem_hs.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } size_e;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        logic [3:0] n;
        unique case (size)
            2'd0:    n = 4'd1;
            2'd1:    n = 4'd2;
            2'd2:    n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Big-endian byte gather/scatter and load sign/zero extension.
// Byte i of rd_bytes/wr_bytes belongs to address addr+i.
module dmem_lane_fmt
    import dmem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] rd_bytes,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] wr_bytes,
    output logic [XLEN-1:0] rdata
);

    localparam int NB = XLEN / 8;

    logic [3:0]      n;
    logic [XLEN-1:0] val;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] top;
    logic            sign;

    always_comb begin
        n        = size_bytes(size);
        val      = '0;
        wr_bytes = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(n)) begin
                // lowest address lands in the most-significant byte
                val = {val[XLEN-9:0], rd_bytes[8*i +: 8]};
                wr_bytes[8*i +: 8] = 8'(wdata >> (8 * (int'(n) - 1 - i)));
            end
        end
        if (int'(n) >= NB) begin
            mask = '1;
        end else begin
            mask = ~({XLEN{1'b1}} << (8 * int'(n)));
        end
        top   = val >> (8 * int'(n) - 1);
        sign  = !is_unsigned && top[0];
        rdata = sign ? (val | ~mask) : val;
    end

endmodule

// File: rtl/dmem_hs.sv
// Handshaked byte-addressable data memory with self-clear after reset.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned accesses.
module dmem_hs
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 8192,
    parameter int XLEN        = 64,
    parameter int ADDR_W      = 64,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int NB    = XLEN / 8;
    localparam int MW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / NB;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [7:0] mem [DEPTH_BYTES];

    state_e            state_q, state_d;
    logic [CW-1:0]     clr_q, clr_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic              accept;
    logic              legal;
    logic              range_ok;
    logic              size_ok;
    logic              mis;
    logic [3:0]        n;
    logic [MW-1:0]     base;
    logic [MW-1:0]     clr_base;
    logic [XLEN-1:0]   rd_bytes;
    logic [XLEN-1:0]   wr_bytes;
    logic [XLEN-1:0]   ld_data;

    dmem_lane_fmt #(.XLEN(XLEN)) u_fmt (
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .rd_bytes    (rd_bytes),
        .wdata       (req_wdata),
        .wr_bytes    (wr_bytes),
        .rdata       (ld_data)
    );

    always_comb begin
        n        = size_bytes(req_size);
        base     = req_addr[MW-1:0];
        clr_base = MW'(clr_q) << $clog2(NB);
        accept   = req_valid && req_ready_q;
        // compare against DEPTH-N so a huge address cannot wrap into range
        range_ok = req_addr <= (ADDR_W'(DEPTH_BYTES) - ADDR_W'(n));
        size_ok  = !((XLEN == 32) && (req_size == 2'd3));
`ifdef DMEM_ALIGN_CHECK_EN
        mis      = |(req_addr[3:0] & (n - 4'd1));
`else
        mis      = 1'b0;
`endif
        legal    = range_ok && size_ok && !mis;
        for (int i = 0; i < NB; i++) begin
            rd_bytes[8*i +: 8] = mem[base + MW'(i)];
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        lat_d       = lat_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            ST_CLEAR: begin
                clr_d = clr_q + CW'(1);
                if (clr_q == CW'(WORDS - 1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) begin
                    rsp_err_d   = !legal;
                    rsp_rdata_d = (legal && !req_we) ? ld_data : '0;
                    lat_d       = LW'((LATENCY > 1) ? LATENCY - 2 : 0);
                    state_d     = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (lat_q == '0) state_d = ST_RESP;
                else             lat_d   = lat_q - LW'(1);
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_CLEAR;
        endcase
        if (rst) begin
            state_d     = ST_CLEAR;
            clr_d       = '0;
            lat_d       = '0;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
        end
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        clr_q       <= clr_d;
        lat_q       <= lat_d;
        req_ready_q <= req_ready_d;
        rsp_valid_q <= rsp_valid_d;
        rsp_err_q   <= rsp_err_d;
        rsp_rdata_q <= rsp_rdata_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                for (int i = 0; i < NB; i++) begin
                    mem[clr_base + MW'(i)] <= 8'h00;
                end
            end else if (accept && legal && req_we) begin
                for (int i = 0; i < NB; i++) begin
                    if (i < int'(n)) mem[base + MW'(i)] <= wr_bytes[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_hs.sv
// Directed scoreboard bench for dmem_hs.
module tb_dmem_hs;

    localparam int XLEN  = 64;
    localparam int AW    = 64;
    localparam int DEPTH = 8192;
    localparam int LAT   = 2;
    localparam int WORDS = DEPTH / (XLEN / 8);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [1:0]      req_size = 2'd0;
    logic            req_unsigned = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [XLEN-1:0] req_wdata = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    typedef struct packed {
        logic        err;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dmem_hs #(
        .DEPTH_BYTES (DEPTH),
        .XLEN        (XLEN),
        .ADDR_W      (AW),
        .LATENCY     (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Counts cycles with req_ready low, starting at the current negedge.
    task automatic clear_wait(input string tag);
        int cnt = 0;
        while (!req_ready && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        check(tag, 64'(cnt), 64'(WORDS));
    endtask

    task automatic do_req(input string tag, input logic we,
                          input logic [1:0] sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input logic err, input logic [63:0] exp,
                          input int hold);
        int   t = 0;
        int   lat = 0;
        exp_t e;
        while (!req_ready && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "/rdy_in"}, 64'(req_ready), 64'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        sb.push_back({err, exp});
        @(posedge clk);
        #1 req_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 50);
        check({tag, "/lat"}, 64'(lat), 64'(LAT));
        e = sb.pop_front();
        check({tag, "/data"}, rsp_rdata, e.data);
        check({tag, "/err"}, 64'(rsp_err), 64'(e.err));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "/hold_v"}, 64'(rsp_valid), 64'd1);
            check({tag, "/hold_d"}, rsp_rdata, e.data);
            check({tag, "/hold_e"}, 64'(rsp_err), 64'(e.err));
            check({tag, "/hold_r"}, 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "/rdy_out"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        @(negedge clk);
        check("rst/rdy", 64'(req_ready), 64'd0);
        check("rst/vld", 64'(rsp_valid), 64'd0);
        check("rst/err", 64'(rsp_err), 64'd0);
        check("rst/data", rsp_rdata, 64'd0);
        rst = 1'b0;
        clear_wait("clear1");

        do_req("ld_clr", 0, 2'd3, 1, 64'h1000, 0, 0, 64'h0, 0);
        do_req("st_d", 1, 2'd3, 0, 64'h10, 64'h0011223344556677, 0, 0, 0);
        do_req("ldb10", 0, 2'd0, 1, 64'h10, 0, 0, 64'h00, 0);
        do_req("ldb17", 0, 2'd0, 1, 64'h17, 0, 0, 64'h77, 0);
        do_req("ldh12", 0, 2'd1, 1, 64'h12, 0, 0, 64'h2233, 0);
        do_req("ldw14", 0, 2'd2, 1, 64'h14, 0, 0, 64'h44556677, 0);
        do_req("ldh10s", 0, 2'd1, 0, 64'h10, 0, 0, 64'h0011, 0);

        do_req("st_b80", 1, 2'd0, 0, 64'h20, 64'hAAAA_0080, 0, 0, 0);
        do_req("ldb_s", 0, 2'd0, 0, 64'h20, 0, 0, 64'hFFFFFFFFFFFFFF80, 0);
        do_req("ldb_u", 0, 2'd0, 1, 64'h20, 0, 0, 64'h80, 0);
        do_req("ldh_21", 0, 2'd1, 1, 64'h20, 0, 0, 64'h8000, 0);

        do_req("st_top", 1, 2'd3, 0, 64'd8184, 64'h8899AABBCCDDEEFF, 0, 0, 0);
        do_req("st_oob", 1, 2'd3, 0, 64'd8190, 64'h1234, 1, 0, 0);
        do_req("ld_top", 0, 2'd3, 1, 64'd8184, 0, 0, 64'h8899AABBCCDDEEFF, 0);
        do_req("ldb_end", 0, 2'd0, 1, 64'd8191, 0, 0, 64'hFF, 0);
        do_req("ldh_end", 0, 2'd1, 0, 64'd8190, 0, 0, 64'hFFFFFFFFFFFFEEFF, 0);
        do_req("ldw_s", 0, 2'd2, 0, 64'd8188, 0, 0, 64'hFFFFFFFFCCDDEEFF, 0);
        do_req("ldh_oob", 0, 2'd1, 1, 64'd8191, 0, 1, 64'h0, 0);
        do_req("ld_wrap", 0, 2'd0, 1, 64'hFFFFFFFFFFFFFFFF, 0, 1, 64'h0, 0);

`ifdef DMEM_ALIGN_CHECK_EN
        do_req("ldw_mis", 0, 2'd2, 1, 64'h11, 0, 1, 64'h0, 0);
        do_req("sth_mis", 1, 2'd1, 0, 64'h21, 64'h5566, 1, 0, 0);
        do_req("ldb_21", 0, 2'd0, 1, 64'h21, 0, 0, 64'h00, 0);
`else
        do_req("ldw_mis", 0, 2'd2, 1, 64'h11, 0, 0, 64'h11223344, 0);
        do_req("sth_mis", 1, 2'd1, 0, 64'h21, 64'h5566, 0, 0, 0);
        do_req("ldw_20", 0, 2'd2, 1, 64'h20, 0, 0, 64'h80556600, 0);
`endif

        do_req("bp", 0, 2'd2, 1, 64'h14, 0, 0, 64'h44556677, 10);

        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'd3;
        req_unsigned = 1'b1;
        req_addr     = 64'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("busy/vld", 64'(rsp_valid), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstb/vld", 64'(rsp_valid), 64'd0);
        check("rstb/rdy", 64'(req_ready), 64'd0);
        check("rstb/data", rsp_rdata, 64'd0);
        clear_wait("clear2");
        do_req("ld_clr2", 0, 2'd3, 1, 64'h10, 0, 0, 64'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
